rvh_l1d_mshr_alloc_ctrl: RTL
============================

Name: rvh_l1d_mshr_alloc_ctrl

Overview:
Allocation controller for the L1D MSHR file. It arbitrates miss requests from N_REQ requesters (load pipes and store buffer) round-robin and grants at most one request per cycle. On a line-address match against a live MSHR it merges the request into that entry; otherwise it allocates the lowest-index free MSHR. It owns the MSHR valid vector, retires entries on refill-done dealloc, and reserves entries for the store requester under pressure.

Parameters:
N_MSHR, 4, number of MSHR entries
N_MSHR_W, 2, log2(N_MSHR)
N_REQ, 2, number of miss requesters; index N_REQ-1 is the store requester
N_REQ_W, 1, log2(N_REQ)
LINE_ADDR_W, 34, cache-line address width
N_RESERVE, 1, free entries withheld from non-store requesters

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-low
req_vld_i  in  N_REQ  per-requester miss request valid
req_line_addr_i  in  N_REQ*LINE_ADDR_W  per-requester line address, requester i at slice i
req_rdy_o  out  N_REQ  one-hot grant; a request fires when req_vld_i[i] and req_rdy_o[i] are both high
resp_id_o  out  N_MSHR_W  MSHR id for the fired request, valid in the fire cycle
resp_merge_o  out  1  fired request merged into an existing entry (no new allocation)
resp_req_idx_o  out  N_REQ_W  index of the fired requester
dealloc_vld_i  in  1  refill done; free one entry
dealloc_id_i  in  N_MSHR_W  id of the entry to free
mshr_valid_o  out  N_MSHR  registered entry-valid vector
free_num_o  out  N_MSHR_W+1  registered free-entry count
full_o  out  1  registered; no free entries

Behaviour:
- Reset (rst==0 at posedge): valid vector = 0, stored line addresses = 0, rr_ptr = 0, free_num_o = N_MSHR, full_o = 0. Combinational outputs are zero while req_vld_i = 0.
- State: valid[N_MSHR], line_addr[N_MSHR], rr_ptr[N_REQ_W].
- Match: requester i hits entry k if valid[k], dealloc does not target k this cycle, and line_addr[k] == req_line_addr_i[i]. At most one entry can match, because merging prevents duplicates.
- Eligibility: requester i is eligible if req_vld_i[i] and one of:
  - it matches an entry;
  - it is the store requester and free_count > 0;
  - it is a non-store requester and free_count > N_RESERVE.
- free_count is computed from the registered valid vector only. An entry freed this cycle is not reusable until the next cycle.
- Arbitration: grant the first eligible requester scanning from rr_ptr upward with wrap. On a fire, rr_ptr <= granted index + 1 mod N_REQ. With no fire, rr_ptr holds.
- Grant is combinational, same cycle. req_rdy_o is at most one-hot and never depends on the requester's own ready.
- Fire with match: resp_merge_o = 1, resp_id_o = the matched entry, no state change.
- Fire without match: resp_id_o = lowest-index invalid entry, valid <= 1, line_addr <= request address.
- Dealloc: valid[dealloc_id_i] <= 0 at the next edge.
  - Dealloc of an already-invalid entry is ignored. The bench flags it with an assertion.
  - Same-cycle dealloc of entry k and allocation never conflict, because allocation picks an entry that is invalid in the registered vector.
- Address equality between two simultaneous requesters: only one fires. The loser re-requests next cycle and then merges.
- full_o and free_num_o reflect the post-update valid vector, so they are registered, 1-cycle latency.
- Reset mid-operation: all entries drop immediately at the reset edge. Requesters' outstanding ids are void; this is the owner's responsibility.

Decomposition:
- Package rvh_l1d_mshr_pkg: N_MSHR, N_MSHR_W, N_REQ, LINE_ADDR_W, N_RESERVE, and typedef mshr_id_t.
- Sub-module: instantiate the existing rvh_l1d_mshr_alloc for the free-entry pick and free count, fed with the registered valid vector.
- Round-robin arbitration stays inline.

Test Plan:
1. Reset, then req_vld_i=01, addr 0x100 -> req_rdy_o=01, resp_id_o=0, resp_merge_o=0; next cycle mshr_valid_o=0001, free_num_o=3.
2. Entry 0 holds 0x100; requester 1 sends 0x100 -> rdy=10, resp_merge_o=1, resp_id_o=0; mshr_valid_o unchanged.
3. Both requesters valid every cycle with distinct addresses 0x200, 0x300, 0x400, rr_ptr=0 -> grants alternate 01, 10, 01; ids 0, 1, 2.
4. Three entries valid (free=1, N_RESERVE=1): load-only request -> rdy=00. Store request -> rdy=10, id=3; next cycle full_o=1, free_num_o=0.
5. full_o=1 with dealloc_id_i=2 and a load request in the same cycle -> rdy=00 that cycle; next cycle free_num_o=1, store granted id 2.
6. Entries valid mid-stream, assert rst=0 for one cycle -> mshr_valid_o=0000, free_num_o=4, full_o=0; first post-reset request gets id 0.

Source files
------------

// File: rtl/rvh_l1d_mshr_pkg.sv
// Shared sizing and types for the L1D MSHR allocation logic.
package rvh_l1d_mshr_pkg;

   localparam int N_MSHR      = 4;
   localparam int N_MSHR_W    = 2;
   localparam int N_REQ       = 2;
   localparam int N_REQ_W     = 1;
   localparam int LINE_ADDR_W = 34;
   localparam int N_RESERVE   = 1;

   typedef logic [N_MSHR_W-1:0]    mshr_id_t;
   typedef logic [N_MSHR_W:0]      mshr_cnt_t;
   typedef logic [LINE_ADDR_W-1:0] line_addr_t;
   typedef logic [N_REQ_W-1:0]     req_idx_t;

   typedef struct packed {
      logic     merge;
      mshr_id_t id;
      req_idx_t req_idx;
   } mshr_resp_t;

endpackage

// File: rtl/rvh_l1d_mshr_alloc.sv
// Free-entry picker: lowest-index invalid MSHR and free count, purely combinational.
// No handshake; consumers qualify free_id with free_vld.
module rvh_l1d_mshr_alloc
   import rvh_l1d_mshr_pkg::*;
(
   input  logic [N_MSHR-1:0] valid,
   output logic              free_vld,
   output mshr_id_t          free_id,
   output mshr_cnt_t         free_num
);

   // Scan downward so the lowest invalid index is the last one written.
   always_comb begin
      free_vld = 1'b0;
      free_id  = '0;
      free_num = '0;
      for (int k = N_MSHR - 1; k >= 0; k--) begin
         if (!valid[k]) begin
            free_vld = 1'b1;
            free_id  = mshr_id_t'(k);
            free_num = free_num + mshr_cnt_t'(1);
         end
      end
   end

endmodule

// File: rtl/rvh_l1d_mshr_alloc_ctrl.sv
// MSHR allocation control: round-robin grant of one miss per cycle, merge on line match, else allocate.
// Grant/response are same-cycle combinational; valid/free/full outputs are registered (1-cycle latency).
module rvh_l1d_mshr_alloc_ctrl
   import rvh_l1d_mshr_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req_vld_i,
   input  logic [N_REQ*LINE_ADDR_W-1:0] req_line_addr_i,
   output logic [N_REQ-1:0]             req_rdy_o,
   output logic [N_MSHR_W-1:0]          resp_id_o,
   output logic                         resp_merge_o,
   output logic [N_REQ_W-1:0]           resp_req_idx_o,
   input  logic                         dealloc_vld_i,
   input  logic [N_MSHR_W-1:0]          dealloc_id_i,
   output logic [N_MSHR-1:0]            mshr_valid_o,
   output logic [N_MSHR_W:0]            free_num_o,
   output logic                         full_o
);

   localparam mshr_cnt_t RESERVE_CNT = mshr_cnt_t'(N_RESERVE);

   logic [N_MSHR-1:0] valid_q;
   logic [N_MSHR-1:0] valid_nxt;
   line_addr_t        line_addr_q [N_MSHR];
   req_idx_t          rr_ptr_q;
   req_idx_t          rr_ptr_nxt;
   mshr_cnt_t         free_num_q;
   mshr_cnt_t         free_num_nxt;
   logic              full_q;

   logic              free_vld;
   mshr_id_t          free_id;
   mshr_cnt_t         free_cnt;

   line_addr_t        req_addr  [N_REQ];
   logic [N_REQ-1:0]  match_any;
   mshr_id_t          match_id  [N_REQ];
   logic [N_REQ-1:0]  elig;

   logic              gnt_vld;
   req_idx_t          gnt_idx;
   logic              alloc;
   mshr_resp_t        resp;

   rvh_l1d_mshr_alloc u_alloc (
      .valid    (valid_q),
      .free_vld (free_vld),
      .free_id  (free_id),
      .free_num (free_cnt)
   );

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         req_addr[i] = req_line_addr_i[i*LINE_ADDR_W +: LINE_ADDR_W];
      end
   end

   // An entry being retired this cycle no longer accepts merges.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         match_any[i] = 1'b0;
         match_id[i]  = '0;
         for (int k = 0; k < N_MSHR; k++) begin
            if (valid_q[k]
                && !(dealloc_vld_i && (dealloc_id_i == mshr_id_t'(k)))
                && (line_addr_q[k] == req_addr[i])) begin
               match_any[i] = 1'b1;
               match_id[i]  = mshr_id_t'(k);
            end
         end
         if (i == N_REQ - 1) begin
            elig[i] = req_vld_i[i] && (match_any[i] || (free_cnt != '0));
         end else begin
            elig[i] = req_vld_i[i] && (match_any[i] || (free_cnt > RESERVE_CNT));
         end
      end
   end

   // Scan offsets downward so the requester closest to rr_ptr wins.
   always_comb begin
      int idx;
      idx     = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int off = N_REQ - 1; off >= 0; off--) begin
         idx = (int'(rr_ptr_q) + off) % N_REQ;
         if (elig[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = req_idx_t'(idx);
         end
      end
   end

   always_comb begin
      resp       = '0;
      req_rdy_o  = '0;
      alloc      = 1'b0;
      rr_ptr_nxt = rr_ptr_q;
      if (gnt_vld) begin
         req_rdy_o[gnt_idx] = 1'b1;
         resp.req_idx       = gnt_idx;
         resp.merge         = match_any[gnt_idx];
         resp.id            = match_any[gnt_idx] ? match_id[gnt_idx] : free_id;
         alloc              = !match_any[gnt_idx] && free_vld;
         rr_ptr_nxt         = req_idx_t'((int'(gnt_idx) + 1) % N_REQ);
      end
   end

   assign resp_id_o      = resp.id;
   assign resp_merge_o   = resp.merge;
   assign resp_req_idx_o = resp.req_idx;

   // Allocation targets a registered-invalid entry, so it never collides with a live dealloc.
   always_comb begin
      valid_nxt = valid_q;
      if (dealloc_vld_i && valid_q[dealloc_id_i]) begin
         valid_nxt[dealloc_id_i] = 1'b0;
      end
      if (alloc) begin
         valid_nxt[free_id] = 1'b1;
      end
      free_num_nxt = '0;
      for (int k = 0; k < N_MSHR; k++) begin
         if (!valid_nxt[k]) begin
            free_num_nxt = free_num_nxt + mshr_cnt_t'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q    <= '0;
         rr_ptr_q   <= '0;
         free_num_q <= mshr_cnt_t'(N_MSHR);
         full_q     <= 1'b0;
         for (int k = 0; k < N_MSHR; k++) begin
            line_addr_q[k] <= '0;
         end
      end else begin
         valid_q    <= valid_nxt;
         rr_ptr_q   <= rr_ptr_nxt;
         free_num_q <= free_num_nxt;
         full_q     <= (free_num_nxt == '0);
         if (alloc) begin
            line_addr_q[free_id] <= req_addr[gnt_idx];
         end
      end
   end

   assign mshr_valid_o = valid_q;
   assign free_num_o   = free_num_q;
   assign full_o       = full_q;

endmodule
